// File: rtl/dmem_responder_if.sv
//----------------------------------------------------------------------------
// Module      : dmem_responder_if
// Description : Data-memory bus between the core MEM stage (master) and the
//               data-memory responder (slave).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface dmem_responder_if;
    logic [3:0]  DMEM_write_byte_i;
    logic        DMEM_read_i;
    logic [31:0] DMEM_addr_i;
    logic [31:0] DMEM_data_i;
    logic [31:0] DMEM_data_o;

    modport master (
        output DMEM_write_byte_i,
        output DMEM_read_i,
        output DMEM_addr_i,
        output DMEM_data_i,
        input  DMEM_data_o
    );

    modport slave (
        input  DMEM_write_byte_i,
        input  DMEM_read_i,
        input  DMEM_addr_i,
        input  DMEM_data_i,
        output DMEM_data_o
    );
endinterface

`default_nettype wire

// File: rtl/dmem_responder.sv
//----------------------------------------------------------------------------
// Module      : dmem_responder
// Description : Slave end of the core data-memory bus. Byte-writable word
//               RAM plus an MMIO window holding a console TX FIFO, a cycle
//               counter and a TOHOST halt register.
//               Optional feature macro: DMEM_CYCLE_CNT_EN (cycle counter).
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
    parameter int          ADDR_W     = 12,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
    input  wire               clk,
    input  wire               reset_n,
    dmem_responder_if.slave   dmem,
    output logic              con_valid_o,
    output logic [7:0]        con_data_o,
    input  wire               con_ready_i,
    output logic              halt_o,
    output logic [30:0]       exit_code_o,
    output logic              bus_err_o
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    // Address decode and access classification
    logic              w_is_ram;
    logic              w_is_mmio;
    logic [31:0]       w_mmio_off;
    logic [9:0]        w_reg_sel;
    logic              w_wr;
    logic              w_err;
    logic              w_unused_ok;

    assign w_is_ram   = (dmem.DMEM_addr_i[31:ADDR_W+2] == '0);
    assign w_mmio_off = dmem.DMEM_addr_i - MMIO_BASE;
    assign w_is_mmio  = !w_is_ram && (w_mmio_off < 32'h0000_1000);
    assign w_reg_sel  = w_mmio_off[11:2];
    assign w_wr       = |dmem.DMEM_write_byte_i;
    assign w_err      = (w_wr || dmem.DMEM_read_i) && !w_is_ram && !w_is_mmio;
    // Byte-offset bits are ignored: all accesses are whole-word.
    assign w_unused_ok = &{1'b0, dmem.DMEM_addr_i[1:0]};

    // Data RAM, no reset; nonblocking write gives read-before-write ordering
    logic [31:0] r_mem [2**ADDR_W];

    // Byte-lane write into the RAM word
    always_ff @(posedge clk) begin
        if (w_is_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (dmem.DMEM_write_byte_i[k])
                    r_mem[dmem.DMEM_addr_i[ADDR_W+1:2]][8*k +: 8] <= dmem.DMEM_data_i[8*k +: 8];
            end
        end
    end

    // Console FIFO state
    logic [7:0]         r_fifo [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               r_overflow;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_req;
    logic               w_push;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;
    logic [7:0]         w_head_nxt;

    assign w_full       = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_pop        = con_valid_o && con_ready_i;
    assign w_push_req   = w_is_mmio && (w_reg_sel == 10'd0) && dmem.DMEM_write_byte_i[0];
    // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted.
    assign w_push       = w_push_req && (!w_full || w_pop);
    assign w_count_nxt  = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    assign w_rd_ptr_nxt = r_rd_ptr + c_ptr_w'(w_pop);
    // A byte pushed into an (effectively) empty FIFO becomes the next head directly.
    assign w_head_nxt   = (w_push && (r_count == c_cnt_w'(w_pop))) ? dmem.DMEM_data_i[7:0]
                                                                   : r_fifo[w_rd_ptr_nxt];

    // FIFO storage write, contents are not reset
    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= dmem.DMEM_data_i[7:0];
    end

    // FIFO pointers, count, sticky overflow and registered head/valid
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            con_valid_o <= 1'b0;
            con_data_o  <= 8'h00;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            if (w_push_req && !w_push)
                r_overflow <= 1'b1;
            con_valid_o <= (w_count_nxt != '0);
            if (w_count_nxt != '0)
                con_data_o <= w_head_nxt;
        end
    end

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] r_cycle;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_cycle <= '0;
        else
            r_cycle <= r_cycle + 32'd1;
    end
`endif

    // TOHOST: first qualifying write halts and latches the exit code
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            halt_o      <= 1'b0;
            exit_code_o <= '0;
        end else if (w_is_mmio && w_wr && (w_reg_sel == 10'd2) &&
                     dmem.DMEM_data_i[0] && !halt_o) begin
            halt_o      <= 1'b1;
            exit_code_o <= dmem.DMEM_data_i[31:1];
        end
    end

    // MMIO read mux, built from pre-access register state
    logic [31:0] w_mmio_rdata;

    always_comb begin
        w_mmio_rdata = '0;
        case (w_reg_sel)
            10'd0:   w_mmio_rdata = {16'b0, 8'(r_count), 5'b0, r_overflow, w_full, w_empty};
`ifdef DMEM_CYCLE_CNT_EN
            10'd1:   w_mmio_rdata = r_cycle;
`endif
            10'd2:   w_mmio_rdata = {exit_code_o, halt_o};
            default: w_mmio_rdata = '0;
        endcase
    end

    // Registered read data (held between reads) and one-cycle error pulse
    logic [31:0] r_rd_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
            bus_err_o <= 1'b0;
        end else begin
            bus_err_o <= w_err;
            if (dmem.DMEM_read_i) begin
                if (w_is_ram)
                    r_rd_data <= r_mem[dmem.DMEM_addr_i[ADDR_W+1:2]];
                else if (w_is_mmio)
                    r_rd_data <= w_mmio_rdata;
                else
                    r_rd_data <= '0;
            end
        end
    end

    assign dmem.DMEM_data_o = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//----------------------------------------------------------------------------
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    localparam logic [31:0] c_mmio = 32'h8000_0000;

    logic       clk;
    logic       reset_n;
    logic       con_ready_i;
    logic       con_valid_o;
    logic [7:0] con_data_o;
    logic       halt_o;
    logic [30:0] exit_code_o;
    logic       bus_err_o;

    int nt;
    int nf;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_W     (12),
        .FIFO_DEPTH (8),
        .MMIO_BASE  (c_mmio)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .dmem        (bus),
        .con_valid_o (con_valid_o),
        .con_data_o  (con_data_o),
        .con_ready_i (con_ready_i),
        .halt_o      (halt_o),
        .exit_code_o (exit_code_o),
        .bus_err_o   (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: inputs held across a rising edge, outputs sampled 1ns later.
    task automatic bus_cycle(input logic [3:0] be, input logic rd,
                             input logic [31:0] addr, input logic [31:0] data);
        bus.DMEM_write_byte_i = be;
        bus.DMEM_read_i       = rd;
        bus.DMEM_addr_i       = addr;
        bus.DMEM_data_i       = data;
        @(posedge clk);
        #1;
        bus.DMEM_write_byte_i = 4'b0;
        bus.DMEM_read_i       = 1'b0;
        bus.DMEM_addr_i       = 32'h0;
        bus.DMEM_data_i       = 32'h0;
    endtask

    task automatic do_reset();
        reset_n               = 1'b0;
        con_ready_i           = 1'b0;
        bus.DMEM_write_byte_i = 4'b0;
        bus.DMEM_read_i       = 1'b0;
        bus.DMEM_addr_i       = 32'h0;
        bus.DMEM_data_i       = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        nt++; if (bus.DMEM_data_o !== 32'h0) begin nf++; $display("FAIL reset_data: got %h exp 00000000", bus.DMEM_data_o); end
        nt++; if (con_valid_o !== 1'b0) begin nf++; $display("FAIL reset_con_valid: got %b exp 0", con_valid_o); end
        nt++; if (con_data_o !== 8'h00) begin nf++; $display("FAIL reset_con_data: got %h exp 00", con_data_o); end
        nt++; if (halt_o !== 1'b0) begin nf++; $display("FAIL reset_halt: got %b exp 0", halt_o); end
        nt++; if (exit_code_o !== 31'h0) begin nf++; $display("FAIL reset_exit: got %h exp 0", exit_code_o); end
        nt++; if (bus_err_o !== 1'b0) begin nf++; $display("FAIL reset_bus_err: got %b exp 0", bus_err_o); end
    endtask

    task automatic test_byte_write();
        bus_cycle(4'b1111, 1'b0, 32'h10, 32'hDEAD_BEEF);
        bus_cycle(4'b0001, 1'b0, 32'h10, 32'h0000_00AA);
        bus_cycle(4'b0000, 1'b1, 32'h10, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'hDEAD_BEAA) begin nf++; $display("FAIL byte_write: got %h exp deadbeaa", bus.DMEM_data_o); end
        bus_cycle(4'b1100, 1'b0, 32'h10, 32'h1234_5678);
        nt++; if (bus.DMEM_data_o !== 32'hDEAD_BEAA) begin nf++; $display("FAIL read_hold: got %h exp deadbeaa", bus.DMEM_data_o); end
        bus_cycle(4'b0000, 1'b1, 32'h10, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h1234_BEAA) begin nf++; $display("FAIL upper_lanes: got %h exp 1234beaa", bus.DMEM_data_o); end
        // Top RAM word is in range; the next word is not.
        bus_cycle(4'b1111, 1'b0, 32'h3FFC, 32'hCAFE_F00D);
        bus_cycle(4'b0000, 1'b1, 32'h3FFC, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'hCAFE_F00D || bus_err_o !== 1'b0) begin nf++; $display("FAIL ram_top: got %h err %b exp cafef00d err 0", bus.DMEM_data_o, bus_err_o); end
    endtask

    task automatic test_read_before_write();
        bus_cycle(4'b1111, 1'b0, 32'h20, 32'h1111_1111);
        bus_cycle(4'b1111, 1'b1, 32'h20, 32'h2222_2222);
        nt++; if (bus.DMEM_data_o !== 32'h1111_1111) begin nf++; $display("FAIL rbw_old: got %h exp 11111111", bus.DMEM_data_o); end
        bus_cycle(4'b0000, 1'b1, 32'h20, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h2222_2222) begin nf++; $display("FAIL rbw_new: got %h exp 22222222", bus.DMEM_data_o); end
    endtask

    task automatic test_console_overflow();
        con_ready_i = 1'b0;
        for (int i = 0; i < 9; i++)
            bus_cycle(4'b0001, 1'b0, c_mmio, 32'h41 + i);
        bus_cycle(4'b0000, 1'b1, c_mmio, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h0000_0806) begin nf++; $display("FAIL ovf_status: got %h exp 00000806", bus.DMEM_data_o); end
        con_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nt++;
            if (con_valid_o !== 1'b1 || con_data_o !== 8'(8'h41 + i)) begin
                nf++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h exp v=1 d=%h", i, con_valid_o, con_data_o, 8'(8'h41 + i));
            end
            bus_cycle(4'b0000, 1'b0, 32'h0, 32'h0);
        end
        con_ready_i = 1'b0;
        nt++; if (con_valid_o !== 1'b0) begin nf++; $display("FAIL ovf_empty_valid: got %b exp 0", con_valid_o); end
        bus_cycle(4'b0000, 1'b1, c_mmio, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h0000_0005) begin nf++; $display("FAIL ovf_empty_status: got %h exp 00000005", bus.DMEM_data_o); end
        // A write without lane 0 must not push.
        bus_cycle(4'b1110, 1'b0, c_mmio, 32'h7777_7777);
        nt++; if (con_valid_o !== 1'b0) begin nf++; $display("FAIL lane0_only: got %b exp 0", con_valid_o); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 8; i++)
            bus_cycle(4'b0001, 1'b0, c_mmio, 32'h61 + i);
        nt++; if (con_valid_o !== 1'b1 || con_data_o !== 8'h61) begin nf++; $display("FAIL fp_head: got v=%b d=%h exp v=1 d=61", con_valid_o, con_data_o); end
        // Status read coincident with a push reports the pre-push state.
        con_ready_i = 1'b1;
        bus_cycle(4'b0001, 1'b1, c_mmio, 32'h5A);
        con_ready_i = 1'b0;
        nt++; if (bus.DMEM_data_o !== 32'h0000_0802) begin nf++; $display("FAIL fp_prepush_status: got %h exp 00000802", bus.DMEM_data_o); end
        bus_cycle(4'b0000, 1'b1, c_mmio, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h0000_0802) begin nf++; $display("FAIL fp_status: got %h exp 00000802", bus.DMEM_data_o); end
        con_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nt++;
            if (con_valid_o !== 1'b1 || con_data_o !== ((i == 7) ? 8'h5A : 8'(8'h62 + i))) begin
                nf++; $display("FAIL fp_drain[%0d]: got v=%b d=%h exp v=1 d=%h", i, con_valid_o, con_data_o, (i == 7) ? 8'h5A : 8'(8'h62 + i));
            end
            bus_cycle(4'b0000, 1'b0, 32'h0, 32'h0);
        end
        con_ready_i = 1'b0;
        nt++; if (con_valid_o !== 1'b0) begin nf++; $display("FAIL fp_empty: got %b exp 0", con_valid_o); end
    endtask

    task automatic test_tohost_err();
        bus_cycle(4'b1111, 1'b0, c_mmio + 32'h8, 32'h0000_0007);
        nt++; if (halt_o !== 1'b1 || exit_code_o !== 31'd3) begin nf++; $display("FAIL tohost: got halt=%b code=%0d exp halt=1 code=3", halt_o, exit_code_o); end
        bus_cycle(4'b1111, 1'b0, c_mmio + 32'h8, 32'h0000_0009);
        bus_cycle(4'b0000, 1'b1, c_mmio + 32'h8, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h0000_0007 || exit_code_o !== 31'd3) begin nf++; $display("FAIL tohost_sticky: got rd=%h code=%0d exp rd=00000007 code=3", bus.DMEM_data_o, exit_code_o); end
        bus_cycle(4'b0000, 1'b1, 32'h4000_0000, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h0 || bus_err_o !== 1'b1) begin nf++; $display("FAIL err_read: got rd=%h err=%b exp rd=0 err=1", bus.DMEM_data_o, bus_err_o); end
        bus_cycle(4'b0000, 1'b0, 32'h0, 32'h0);
        nt++; if (bus_err_o !== 1'b0) begin nf++; $display("FAIL err_pulse_len: got %b exp 0", bus_err_o); end
        bus_cycle(4'b1111, 1'b0, 32'h0000_4000, 32'h5555_5555);
        nt++; if (bus_err_o !== 1'b1) begin nf++; $display("FAIL err_write: got %b exp 1", bus_err_o); end
        bus_cycle(4'b0000, 1'b1, c_mmio + 32'h10, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h0 || bus_err_o !== 1'b0) begin nf++; $display("FAIL unmapped_mmio: got rd=%h err=%b exp rd=0 err=0", bus.DMEM_data_o, bus_err_o); end
    endtask

    task automatic test_cycle_counter();
        logic [31:0] v1;
        logic [31:0] v2;
        bus_cycle(4'b0000, 1'b1, c_mmio + 32'h4, 32'h0);
        v1 = bus.DMEM_data_o;
        repeat (9) bus_cycle(4'b0000, 1'b0, 32'h0, 32'h0);
        bus_cycle(4'b0000, 1'b1, c_mmio + 32'h4, 32'h0);
        v2 = bus.DMEM_data_o;
`ifdef DMEM_CYCLE_CNT_EN
        nt++; if (v2 - v1 !== 32'd10) begin nf++; $display("FAIL cycle_delta: got %0d exp 10", v2 - v1); end
`else
        nt++; if (v1 !== 32'h0 || v2 !== 32'h0) begin nf++; $display("FAIL cycle_absent: got %h/%h exp 0/0", v1, v2); end
`endif
    endtask

    task automatic test_reset_mid_read();
        bus_cycle(4'b1111, 1'b0, 32'h30, 32'h1234_5678);
        bus_cycle(4'b0001, 1'b0, c_mmio, 32'h77);
        nt++; if (con_valid_o !== 1'b1 || con_data_o !== 8'h77) begin nf++; $display("FAIL push_visible: got v=%b d=%h exp v=1 d=77", con_valid_o, con_data_o); end
        bus_cycle(4'b0000, 1'b1, 32'h30, 32'h0);
        nt++; if (bus.DMEM_data_o !== 32'h1234_5678) begin nf++; $display("FAIL pre_reset_read: got %h exp 12345678", bus.DMEM_data_o); end
        bus.DMEM_read_i = 1'b1;
        bus.DMEM_addr_i = 32'h10;
        #2;
        reset_n = 1'b0;
        #1;
        nt++; if (bus.DMEM_data_o !== 32'h0) begin nf++; $display("FAIL async_reset_data: got %h exp 00000000", bus.DMEM_data_o); end
        do_reset();
        #1;
        nt++; if (bus.DMEM_data_o !== 32'h0 || con_valid_o !== 1'b0) begin nf++; $display("FAIL post_reset: got rd=%h v=%b exp rd=0 v=0", bus.DMEM_data_o, con_valid_o); end
    endtask

    initial begin
        nt = 0;
        nf = 0;
        test_reset();
        test_byte_write();
        test_read_before_write();
        test_console_overflow();
        test_full_pop();
        test_tohost_err();
        test_cycle_counter();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end

endmodule

`default_nettype wire
